dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port C (pipeline MEM stage, normally highest priority) and port D (DMA/debug master).
- Sits between the MEM stage and the data memory. Drives the dmem_* bus the MEM stage would otherwise drive directly, and returns read data to the owning requester after a fixed memory latency.
- Provides DMA starvation protection and a DMA lock for atomic bursts.

Parameters:
READ_LATENCY  1  cycles from accepted read to valid mem_rdata; legal range 1..4
STARVE_LIMIT  4  consecutive lost cycles after which a pending D request overrides C; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
c_req  in  1  core requests an access this cycle
c_we  in  1  1 = write, 0 = read
c_addr  in  32  core byte address
c_wdata  in  32  core write data
c_be  in  4  core byte enables
c_gnt  out  1  core access issued this cycle (combinational)
c_stall  out  1  c_req & ~c_gnt; pipeline freezes EX/MEM
c_rvalid  out  1  read data for core valid this cycle
d_req  in  1  DMA requests an access this cycle
d_we  in  1  1 = write, 0 = read
d_lock  in  1  keep port ownership after the current grant
d_addr  in  32  DMA byte address
d_wdata  in  32  DMA write data
d_be  in  4  DMA byte enables
d_gnt  out  1  DMA access issued this cycle (combinational)
d_rvalid  out  1  read data for DMA valid this cycle
rdata  out  32  read data, shared by both ports; qualified by c_rvalid/d_rvalid
dmem_addr  out  32  memory address
dmem_data_out  out  32  memory write data
dmem_byte_enable  out  4  memory byte enables
dmem_read  out  1  memory read strobe
dmem_write  out  1  memory write strobe
dmem_data_in  in  32  memory read data, READ_LATENCY cycles after dmem_read

Behaviour:
- Handshake: a requester holds req and all qualifiers stable until the cycle in which its gnt=1. An access completes at the clock edge ending the grant cycle. At most one grant per cycle; c_gnt & d_gnt is never 1.
- Memory bus: dmem_* comes combinationally from the winner. With no grant, dmem_read = dmem_write = 0 and addr/data/be = 0. dmem_read = ~we and dmem_write = we of the winner. Byte enables pass through unchanged.
- FSM states: ARB (reset state) and DLOCK.
- ARB, grant order:
  - If starve_cnt == STARVE_LIMIT and d_req: grant D.
  - Else if c_req: grant C.
  - Else if d_req: grant D.
- ARB transition: a D grant with d_lock=1 moves to DLOCK at the edge.
- DLOCK:
  - c_gnt = 0 always.
  - d_gnt = d_req.
  - Returns to ARB at the first edge where d_lock = 0. d_req = 0 does not exit.
- starve_cnt (4-bit):
  - Cleared when d_gnt or ~d_req.
  - Increments when d_req & ~d_gnt.
  - Saturates at STARVE_LIMIT.
  - Not incremented in DLOCK, since D is never denied there.
- Read return: a READ_LATENCY-deep shift register carries {valid, owner} for each granted read. At the tail, rdata = dmem_data_in, and c_rvalid or d_rvalid pulses for one cycle according to owner. Writes produce no rvalid.
- Back-to-back reads from either port may issue every cycle. Returns arrive in issue order.
- Reset (async):
  - State = ARB, starve_cnt = 0, all return-pipe entries invalid.
  - c_gnt, d_gnt, c_stall, c_rvalid, d_rvalid, dmem_read, dmem_write = 0; rdata, dmem_addr, dmem_data_out, dmem_byte_enable = 0. All are forced while reset is high, regardless of inputs.
  - Reads in flight when reset asserts are discarded; no rvalid follows.
- Simultaneous events: with C and D requesting and starve_cnt at the limit, D wins and C stalls exactly that cycle. A D grant with d_lock=1 on the starvation cycle enters DLOCK.

Test Plan:
- Core only, READ_LATENCY=1: c_req read 0x100, mem returns 0xDEADBEEF → c_gnt=1 same cycle, c_rvalid=1 and rdata=0xDEADBEEF next cycle, d_rvalid=0.
- Core write byte: c_we=1, addr 0x103, be=4'b1000, wdata 0x AA000000 → dmem_write=1, dmem_byte_enable=4'b1000, dmem_addr=0x103, no rvalid.
- Continuous c_req and d_req, STARVE_LIMIT=4 → C granted cycles 1-4, d_gnt=1 and c_stall=1 in cycle 5, starve_cnt back to 0, pattern repeats.
- DMA lock burst: d_lock=1 for 3 reads to 0x200/0x204/0x208 with c_req held → c_gnt=0 throughout; 3 d_rvalid pulses in order; after d_lock drops, C granted next cycle.
- Reset mid-read, READ_LATENCY=3: D read issued, reset pulsed 1 cycle later → no d_rvalid ever, all outputs 0 during reset, state ARB afterwards.
- Interleaved reads, READ_LATENCY=2: C read, D read, C read on consecutive cycles → rvalid owners C, D, C on cycles 3, 4, 5 with matching data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the data-memory port between the MEM stage (C) and a DMA/debug master (D).
// Includes DMA starvation protection, a DMA lock for atomic bursts and an in-order read-return pipe.
module dmem_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    output logic        c_gnt,
    output logic        c_stall,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_lock,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_data_out,
    output logic [3:0]  dmem_byte_enable,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic [31:0] dmem_data_in
);

    typedef enum logic {ARB, DLOCK} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t state, next_state;
    logic [3:0] starve_cnt;
    logic c_win, d_win;
    logic issue_read;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        next_state = state;
        case (state)
            ARB: begin
                if ((starve_cnt == LIMIT) && d_req) begin
                    d_win = 1'b1;
                end else if (c_req) begin
                    c_win = 1'b1;
                end else if (d_req) begin
                    d_win = 1'b1;
                end
                if (d_win && d_lock) begin
                    next_state = DLOCK;
                end
            end
            DLOCK: begin
                d_win = d_req;
                if (!d_lock) begin
                    next_state = ARB;
                end
            end
            default: next_state = ARB;
        endcase
    end

    // Outputs are gated by reset so nothing leaks onto the bus while reset is held.
    always_comb begin
        c_gnt            = c_win & ~reset;
        d_gnt            = d_win & ~reset;
        c_stall          = c_req & ~c_win & ~reset;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_addr        = 32'h0;
        dmem_data_out    = 32'h0;
        dmem_byte_enable = 4'h0;
        if (c_gnt) begin
            dmem_read        = ~c_we;
            dmem_write       = c_we;
            dmem_addr        = c_addr;
            dmem_data_out    = c_wdata;
            dmem_byte_enable = c_be;
        end else if (d_gnt) begin
            dmem_read        = ~d_we;
            dmem_write       = d_we;
            dmem_addr        = d_addr;
            dmem_data_out    = d_wdata;
            dmem_byte_enable = d_be;
        end
    end

    assign issue_read = dmem_read;

    // D only loses cycles in ARB; the count saturates so the override persists until D wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt || !d_req) begin
            starve_cnt <= 4'd0;
        end else if ((state == ARB) && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            pipe_valid[0] <= issue_read;
            pipe_owner[0] <= d_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    always_comb begin
        c_rvalid = 1'b0;
        d_rvalid = 1'b0;
        rdata    = 32'h0;
        if (!reset && pipe_valid[READ_LATENCY-1]) begin
            rdata    = dmem_data_in;
            c_rvalid = ~pipe_owner[READ_LATENCY-1];
            d_rvalid = pipe_owner[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances with READ_LATENCY 1, 2 and 3 share one stimulus stream,
// each backed by a small memory model that returns data READ_LATENCY cycles after the access.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_be, d_be;

    logic        c_gnt_w [3];
    logic        c_stall_w [3];
    logic        c_rvalid_w [3];
    logic        d_gnt_w [3];
    logic        d_rvalid_w [3];
    logic [31:0] rdata_w [3];
    logic [31:0] dmem_addr_w [3];
    logic [31:0] dmem_data_out_w [3];
    logic [3:0]  dmem_be_w [3];
    logic        dmem_read_w [3];
    logic        dmem_write_w [3];
    logic [31:0] dmem_data_in_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a ^ 32'h5A5A0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [31:0] addr_pipe [LAT];

        always_ff @(posedge clk) begin
            addr_pipe[0] <= dmem_addr_w[g];
            for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
        end
        assign dmem_data_in_w[g] = mem_fn(addr_pipe[LAT-1]);

        dmem_arbiter #(.READ_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
            .clk              (clk),
            .reset            (reset),
            .c_req            (c_req),
            .c_we             (c_we),
            .c_addr           (c_addr),
            .c_wdata          (c_wdata),
            .c_be             (c_be),
            .c_gnt            (c_gnt_w[g]),
            .c_stall          (c_stall_w[g]),
            .c_rvalid         (c_rvalid_w[g]),
            .d_req            (d_req),
            .d_we             (d_we),
            .d_lock           (d_lock),
            .d_addr           (d_addr),
            .d_wdata          (d_wdata),
            .d_be             (d_be),
            .d_gnt            (d_gnt_w[g]),
            .d_rvalid         (d_rvalid_w[g]),
            .rdata            (rdata_w[g]),
            .dmem_addr        (dmem_addr_w[g]),
            .dmem_data_out    (dmem_data_out_w[g]),
            .dmem_byte_enable (dmem_be_w[g]),
            .dmem_read        (dmem_read_w[g]),
            .dmem_write       (dmem_write_w[g]),
            .dmem_data_in     (dmem_data_in_w[g])
        );
    end

    // Advance to the next cycle, drive inputs after the edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic creq, input logic cwe, input logic [31:0] caddr,
                                 input logic [31:0] cwdata, input logic [3:0] cbe,
                                 input logic dreq, input logic dwe, input logic dlock,
                                 input logic [31:0] daddr);
        @(posedge clk);
        #2;
        c_req = creq; c_we = cwe; c_addr = caddr; c_wdata = cwdata; c_be = cbe;
        d_req = dreq; d_we = dwe; d_lock = dlock; d_addr = daddr; d_wdata = 32'h0; d_be = 4'hF;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input int k, input string tag);
        checkOutput({tag, " c_gnt"},    32'(c_gnt_w[k]), 32'h0);
        checkOutput({tag, " d_gnt"},    32'(d_gnt_w[k]), 32'h0);
        checkOutput({tag, " c_stall"},  32'(c_stall_w[k]), 32'h0);
        checkOutput({tag, " c_rvalid"}, 32'(c_rvalid_w[k]), 32'h0);
        checkOutput({tag, " d_rvalid"}, 32'(d_rvalid_w[k]), 32'h0);
        checkOutput({tag, " rd"},       32'(dmem_read_w[k]), 32'h0);
        checkOutput({tag, " wr"},       32'(dmem_write_w[k]), 32'h0);
        checkOutput({tag, " addr"},     dmem_addr_w[k], 32'h0);
        checkOutput({tag, " wdata"},    dmem_data_out_w[k], 32'h0);
        checkOutput({tag, " be"},       32'(dmem_be_w[k]), 32'h0);
        checkOutput({tag, " rdata"},    rdata_w[k], 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        #3;
        checkAllZero(0, "reset0");
        @(posedge clk);
        #2 reset = 1'b0;

        // Core read, latency 1
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd c_gnt", 32'(c_gnt_w[0]), 32'h1);
        checkOutput("rd dmem_read", 32'(dmem_read_w[0]), 32'h1);
        checkOutput("rd dmem_addr", dmem_addr_w[0], 32'h100);
        idle();
        checkOutput("rd c_rvalid", 32'(c_rvalid_w[0]), 32'h1);
        checkOutput("rd d_rvalid", 32'(d_rvalid_w[0]), 32'h0);
        checkOutput("rd rdata", rdata_w[0], 32'hDEADBEEF);

        // Core byte write
        applyStimulus(1'b1, 1'b1, 32'h103, 32'hAA000000, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wr dmem_write", 32'(dmem_write_w[0]), 32'h1);
        checkOutput("wr dmem_read", 32'(dmem_read_w[0]), 32'h0);
        checkOutput("wr be", 32'(dmem_be_w[0]), 32'h8);
        checkOutput("wr addr", dmem_addr_w[0], 32'h103);
        checkOutput("wr data", dmem_data_out_w[0], 32'hAA000000);
        idle();
        checkOutput("wr no c_rvalid", 32'(c_rvalid_w[0]), 32'h0);

        // Starvation: D wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h20);
            checkOutput($sformatf("starve c_gnt %0d", i), 32'(c_gnt_w[0]), (i % 5 == 4) ? 32'h0 : 32'h1);
            checkOutput($sformatf("starve d_gnt %0d", i), 32'(d_gnt_w[0]), (i % 5 == 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("starve c_stall %0d", i), 32'(c_stall_w[0]), (i % 5 == 4) ? 32'h1 : 32'h0);
        end
        idle();

        // DMA lock burst with C held
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200);
        checkOutput("lock1 d_gnt", 32'(d_gnt_w[0]), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h204);
        checkOutput("lock2 c_gnt", 32'(c_gnt_w[0]), 32'h0);
        checkOutput("lock2 d_gnt", 32'(d_gnt_w[0]), 32'h1);
        checkOutput("lock2 c_stall", 32'(c_stall_w[0]), 32'h1);
        checkOutput("lock2 d_rvalid", 32'(d_rvalid_w[0]), 32'h1);
        checkOutput("lock2 rdata", rdata_w[0], 32'h5A5A0200);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h208);
        checkOutput("lock3 c_gnt", 32'(c_gnt_w[0]), 32'h0);
        checkOutput("lock3 d_gnt", 32'(d_gnt_w[0]), 32'h1);
        checkOutput("lock3 d_rvalid", 32'(d_rvalid_w[0]), 32'h1);
        checkOutput("lock3 rdata", rdata_w[0], 32'h5A5A0204);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("unlock c_gnt", 32'(c_gnt_w[0]), 32'h1);
        checkOutput("unlock d_rvalid", 32'(d_rvalid_w[0]), 32'h1);
        checkOutput("unlock rdata", rdata_w[0], 32'h5A5A0208);
        idle();
        checkOutput("unlock c_rvalid", 32'(c_rvalid_w[0]), 32'h1);
        checkOutput("unlock c rdata", rdata_w[0], 32'h5A5A0500);
        idle();
        idle();

        // Interleaved reads, latency 2
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h304);
        checkOutput("il2 d_gnt", 32'(d_gnt_w[1]), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h308, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("il3 c_rvalid", 32'(c_rvalid_w[1]), 32'h1);
        checkOutput("il3 d_rvalid", 32'(d_rvalid_w[1]), 32'h0);
        checkOutput("il3 rdata", rdata_w[1], 32'h5A5A0300);
        idle();
        checkOutput("il4 d_rvalid", 32'(d_rvalid_w[1]), 32'h1);
        checkOutput("il4 c_rvalid", 32'(c_rvalid_w[1]), 32'h0);
        checkOutput("il4 rdata", rdata_w[1], 32'h5A5A0304);
        idle();
        checkOutput("il5 c_rvalid", 32'(c_rvalid_w[1]), 32'h1);
        checkOutput("il5 rdata", rdata_w[1], 32'h5A5A0308);
        idle();
        idle();

        // Reset mid-read, latency 3
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h400);
        checkOutput("rst d_gnt", 32'(d_gnt_w[2]), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h44; c_wdata = 32'h55; c_be = 4'hF;
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 32'h66;
        #1;
        checkAllZero(2, "rst held");
        @(posedge clk);
        #2;
        reset = 1'b0;
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        #1;
        checkOutput("rst post d_rvalid 0", 32'(d_rvalid_w[2]), 32'h0);
        for (int i = 1; i < 4; i++) begin
            idle();
            checkOutput($sformatf("rst post d_rvalid %0d", i), 32'(d_rvalid_w[2]), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h20);
        checkOutput("rst arb c_gnt", 32'(c_gnt_w[2]), 32'h1);
        checkOutput("rst arb d_gnt", 32'(d_gnt_w[2]), 32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
